muldiv_seq: RTL and testbench

Sequencer between the control unit and the multi-cycle mult and div units. It accepts one MULT/DIV request at a time and issues a one-cycle start pulse to the selected unit. It then waits for that unit's completion flag and commits the result into the architectural HI/LO registers. It also services direct HI/LO writes (MTHI/MTLO), detects divide-by-zero, and aborts on a completion timeout.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_seq_hilo_regs.sv | 41 ++++
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Must exceed the slowest unit latency (mult: 32 cycles after start).
  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_CNT_W   = 7;

  // Result pair as it lands in the architectural registers.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/muldiv_seq_hilo_regs.sv
// Architectural HI/LO register pair. A commit loads both halves at once;
// direct writes (MTHI/MTLO) load either half independently. The sequencer
// only allows direct writes in IDLE and commits in COMMIT, so the two
// never compete.
module hilo_regs
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        commit_en,
  input  hilo_t       commit_val,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // HI/LO update: commit first, otherwise independent direct writes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit_en) begin
      hi_q <= commit_val.hi;
      lo_q <= commit_val.lo;
    end else begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// MULT/DIV sequencer: accepts one request, pulses the selected unit's start,
// waits (bounded by TIMEOUT) for its completion level, then commits the result
// into HI/LO. Optional perf counters are built when MULDIV_PERF_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_sel,
  output logic        op_ready,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] mult_high,
  input  logic [31:0] mult_low,
  input  logic        mult_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_done,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        op_done,
  output logic        dz_err,
`ifdef MULDIV_PERF_EN
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall,
`endif
  output logic        to_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q;
  logic [31:0]      a_q, b_q;
  hilo_t            res_q;
  logic             dz_q, dz_d;
  logic             to_q, to_d;
  logic             accept;
  logic             unit_done;

  assign accept    = (state_q == IDLE) && op_valid;
  // Only the launched unit's flag matters; the other may hold a stale level.
  assign unit_done = (sel_q == OP_MULT) ? mult_done : div_done;

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, including divide-by-zero and timeout detection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (op_valid) begin
          if (op_sel == OP_DIV && rt_val == '0) dz_d = 1'b1;
          else state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion is checked first so it wins over a coincident timeout.
        if (unit_done) begin
          state_d = COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    op_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    mult_start = (state_q == LAUNCH) && (sel_q == OP_MULT);
    div_start  = (state_q == LAUNCH) && (sel_q == OP_DIV);
    op_done    = (state_q == COMMIT);
  end

  // Operand latch, captured result and registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      dz_q  <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      dz_q <= dz_d;
      to_q <= to_d;
      if (accept) begin
        sel_q <= op_sel;
        a_q   <= rs_val;
        b_q   <= rt_val;
      end
      if (state_q == WAIT && unit_done) begin
        res_q <= (sel_q == OP_MULT) ? hilo_t'({mult_high, mult_low})
                                    : hilo_t'({div_hi, div_lo});
      end
    end
  end

  assign unit_a = a_q;
  assign unit_b = b_q;
  assign dz_err = dz_q;
  assign to_err = to_q;

  // Direct writes are dropped outside IDLE.
  hilo_regs u_hilo (
    .clk        (clk),
    .reset      (reset),
    .hi_we      (hi_we && (state_q == IDLE)),
    .lo_we      (lo_we && (state_q == IDLE)),
    .wdata      (wdata),
    .commit_en  (state_q == COMMIT),
    .commit_val (res_q),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

`ifdef MULDIV_PERF_EN
  logic [15:0] perf_ops_q, perf_stall_q;

  // Saturating commit and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == COMMIT && perf_ops_q != 16'hFFFF) perf_ops_q <= perf_ops_q + 16'd1;
      if (busy && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with behavioural mult/div unit stubs.
// Perf ports are connected when MULDIV_PERF_EN is defined.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_sel, op_ready;
  logic [31:0] rs_val, rt_val;
  logic        mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic [31:0] mult_high = '0, mult_low = '0;
  logic        mult_done = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic        div_done = 1'b0;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi_out, lo_out;
  logic        busy, op_done, dz_err, to_err;
`ifdef MULDIV_PERF_EN
  logic [15:0] perf_ops, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  // Event counters, sampled on each rising edge (pre-edge values).
  int ms_cnt = 0, ds_cnt = 0, od_cnt = 0, to_cnt = 0, busy_cnt = 0;

  // Stub controls.
  int div_lat  = 10;
  bit div_hang = 1'b0;
  int m_cnt = 0, d_cnt = 0;
  bit m_run = 1'b0, d_run = 1'b0;
  localparam int MULT_LAT = 32;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_sel     (op_sel),
    .op_ready   (op_ready),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mult_start (mult_start),
    .div_start  (div_start),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mult_high  (mult_high),
    .mult_low   (mult_low),
    .mult_done  (mult_done),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .div_done   (div_done),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .op_done    (op_done),
    .dz_err     (dz_err),
`ifdef MULDIV_PERF_EN
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall),
`endif
    .to_err     (to_err)
  );

  // Signed multiplier stub: done level rises MULT_LAT edges after the start
  // edge and stays high until the next start.
  always @(posedge clk) begin
    if (mult_start) begin
      m_cnt     <= 0;
      m_run     <= 1'b1;
      mult_done <= 1'b0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == MULT_LAT) begin
        mult_done <= 1'b1;
        m_run     <= 1'b0;
        {mult_high, mult_low} <= 64'(signed'(unit_a)) * 64'(signed'(unit_b));
      end
    end
  end

  // Divider stub: remainder/quotient after div_lat edges, or never if hung.
  always @(posedge clk) begin
    if (div_start) begin
      d_cnt    <= 0;
      d_run    <= !div_hang;
      div_done <= 1'b0;
    end else if (d_run) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt + 1 == div_lat) begin
        div_done <= 1'b1;
        d_run    <= 1'b0;
        div_hi   <= unit_a % unit_b;
        div_lo   <= unit_a / unit_b;
      end
    end
  end

  always @(posedge clk) begin
    if (mult_start) ms_cnt++;
    if (div_start)  ds_cnt++;
    if (op_done)    od_cnt++;
    if (to_err)     to_cnt++;
    if (busy)       busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    ms_cnt = 0; ds_cnt = 0; od_cnt = 0; to_cnt = 0; busy_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until op_done is seen (bounded); returns the number of steps taken.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (op_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, op_done, 1'b1);
  endtask

  int n;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_sel = 1'b0; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    step();
    step();

    // Reset state.
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_unit_a", unit_a, 32'h0);
    check("rst_starts", {mult_start, div_start, op_done, dz_err, to_err}, 5'b0);
    reset = 1'b0;
    step();

    // MULT 3 * -2 = -6.
    clr();
    op_valid = 1'b1; op_sel = 1'b0; rs_val = 32'd3; rt_val = 32'hFFFF_FFFE;
    step();
    op_valid = 1'b0;
    check("mul_launch_start", {mult_start, div_start}, 2'b10);
    check("mul_launch_busy", {busy, op_ready}, 2'b10);
    check("mul_unit_a", unit_a, 32'd3);
    check("mul_unit_b", unit_b, 32'hFFFF_FFFE);
    wait_done("mul_done_seen", n);
    step();
    check("mul_e2e_cycles", n + 1, 35);
    check("mul_hi", hi_out, 32'hFFFF_FFFF);
    check("mul_lo", lo_out, 32'hFFFF_FFFA);
    check("mul_start_count", ms_cnt, 1);
    check("mul_div_start_count", ds_cnt, 0);
    check("mul_op_done_count", od_cnt, 1);
    check("mul_ready_after", op_ready, 1'b1);

    // DIV 7 / 2 with an MTLO in the accept cycle and an MTHI while busy.
    clr();
    div_lat = 10;
    op_valid = 1'b1; op_sel = 1'b1; rs_val = 32'd7; rt_val = 32'd2;
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    step();
    op_valid = 1'b0; lo_we = 1'b0;
    check("div_same_cycle_mtlo", lo_out, 32'h0000_DEAD);
    check("div_launch_start", {mult_start, div_start}, 2'b01);
    step();
    hi_we = 1'b1; wdata = 32'h0000_1234;
    step();
    hi_we = 1'b0;
    check("mthi_busy_ignored", hi_out, 32'hFFFF_FFFF);
    wait_done("div_done_seen", n);
    step();
    check("div_hi", hi_out, 32'd1);
    check("div_lo", lo_out, 32'd3);
    check("div_start_count", ds_cnt, 1);
    check("div_mult_start_count", ms_cnt, 0);
    check("div_busy_cycles", busy_cnt, 13);

    // Preload HI/LO, then DIV by zero.
    hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h0000_AAAA;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5555;
    step();
    lo_we = 1'b0;
    check("preload_hi", hi_out, 32'h0000_AAAA);
    check("preload_lo", lo_out, 32'h0000_5555);
    clr();
    op_valid = 1'b1; op_sel = 1'b1; rs_val = 32'd9; rt_val = 32'd0;
    step();
    op_valid = 1'b0;
    check("dz_pulse", dz_err, 1'b1);
    check("dz_ready", {op_ready, busy}, 2'b10);
    step();
    check("dz_pulse_end", dz_err, 1'b0);
    check("dz_no_start", ds_cnt + ms_cnt, 0);
    check("dz_hilo", {hi_out, lo_out}, {32'h0000_AAAA, 32'h0000_5555});

    // Divider never completes: abort after 64 WAIT cycles.
    clr();
    div_hang = 1'b1;
    op_valid = 1'b1; op_sel = 1'b1; rs_val = 32'd5; rt_val = 32'd1;
    step();
    op_valid = 1'b0;
    n = 0;
    while (to_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("to_seen", to_err, 1'b1);
    check("to_cycles", n, 65);
    check("to_ready", op_ready, 1'b1);
    step();
    check("to_one_pulse", to_cnt, 1);
    check("to_no_commit", od_cnt, 0);
    check("to_hilo", {hi_out, lo_out}, {32'h0000_AAAA, 32'h0000_5555});
    div_hang = 1'b0;

    // Done arrives in the 64th WAIT cycle: completion wins over timeout.
    clr();
    div_lat = 63;
    op_valid = 1'b1; op_sel = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    step();
    op_valid = 1'b0;
    wait_done("edge_done_seen", n);
    step();
    check("edge_no_timeout", to_cnt, 0);
    check("edge_hilo", {hi_out, lo_out}, {32'd2, 32'd14});

    // Stale mult_done still high from the first MULT.
    clr();
    op_valid = 1'b1; op_sel = 1'b0; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
    step();
    op_valid = 1'b0;
    wait_done("stale_done_seen", n);
    step();
    check("stale_e2e_cycles", n + 1, 35);
    check("stale_commits", od_cnt, 1);
    check("stale_hilo", {hi_out, lo_out}, {32'd1, 32'd0});

    // Reset in the middle of WAIT discards the operation.
    clr();
    op_valid = 1'b1; op_sel = 1'b0; rs_val = 32'd5; rt_val = 32'd6;
    step();
    op_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_ready", {op_ready, busy}, 2'b10);
    check("rstmid_hilo", {hi_out, lo_out}, 64'h0);
    repeat (40) step();
    check("rstmid_no_commit", od_cnt, 0);
    check("rstmid_hilo_late", {hi_out, lo_out}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
